// File: rtl/keccak_defs.sv
// Keccak absorb definitions: mode encodings, FSM states, rate table and padding suffixes.
package keccak_defs;

  localparam int unsigned MAX_RATE = 168;
  localparam int unsigned BW_IBLEN = 11;
  localparam int unsigned RATE_W   = $clog2(MAX_RATE + 1);

  typedef enum logic [1:0] {
    MODE_SHA3_256 = 2'd0,
    MODE_SHA3_512 = 2'd1,
    MODE_SHAKE128 = 2'd2,
    MODE_SHAKE256 = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_EMIT = 2'd2
  } absorb_state_e;

  localparam logic [7:0] SFX_SHA3  = 8'h06;
  localparam logic [7:0] SFX_SHAKE = 8'h1F;
  localparam logic [7:0] SFX_LAST  = 8'h80;

  function automatic logic [RATE_W-1:0] rate_of(input mode_e mode);
    case (mode)
      MODE_SHA3_512: return RATE_W'(72);
      MODE_SHAKE128: return RATE_W'(168);
      default:       return RATE_W'(136);
    endcase
  endfunction

  function automatic logic [7:0] suffix_of(input mode_e mode);
    return (mode == MODE_SHAKE128 || mode == MODE_SHAKE256) ? SFX_SHAKE : SFX_SHA3;
  endfunction

endpackage

// File: rtl/keccak_pad_mask.sv
// Domain-separation + pad10*1 OR-mask for one rate-sized block.
module keccak_pad_mask #(
  parameter  int unsigned MAX_RATE = keccak_defs::MAX_RATE,
  localparam int unsigned RW       = $clog2(MAX_RATE + 1)
) (
  input  logic [RW-1:0]         pos_i,
  input  logic [RW-1:0]         rate_i,
  input  logic [1:0]            mode_i,
  output logic [MAX_RATE*8-1:0] mask_c
);
  import keccak_defs::*;

  logic [7:0]    sfx;
  logic [RW-1:0] last_idx;

  // Suffix and final 0x80 share a byte when pos = rate-1.
  always_comb begin
    sfx      = suffix_of(mode_e'(mode_i));
    last_idx = rate_i - RW'(1);
    mask_c   = '0;
    for (int unsigned k = 0; k < MAX_RATE; k++) begin
      if (RW'(k) == pos_i)    mask_c[8*k +: 8] = sfx;
      if (RW'(k) == last_idx) mask_c[8*k +: 8] = mask_c[8*k +: 8] | SFX_LAST;
    end
  end

endmodule

// File: rtl/keccak_absorb_pad.sv
// Keccak absorb front end: packs message words into rate blocks, pads the tail and
// hands blocks to the permutation core over valid/ready.
module keccak_absorb_pad #(
  parameter int unsigned BW_DATA  = 64,
  parameter int unsigned BW_IBLEN = keccak_defs::BW_IBLEN,
  parameter int unsigned MAX_RATE = keccak_defs::MAX_RATE
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_start,
  input  logic [1:0]            i_mode,
  input  logic [BW_IBLEN-1:0]   i_ibytes_len,
  input  logic [BW_DATA-1:0]    i_ibytes,
  input  logic                  i_ibytes_valid,
  output logic                  o_ibytes_ready,
  output logic [MAX_RATE*8-1:0] o_blk,
  output logic                  o_blk_valid,
  output logic                  o_blk_last,
  input  logic                  i_blk_ready,
  output logic                  o_busy
);
  import keccak_defs::*;

  localparam int unsigned WB     = BW_DATA / 8;
  localparam int unsigned BLK_W  = MAX_RATE * 8;
  localparam int unsigned RW     = $clog2(MAX_RATE + 1);
  localparam int unsigned WCNT_W = $clog2(MAX_RATE / WB + 1);
  localparam int unsigned BIT_W  = $clog2(BLK_W);
  localparam int unsigned TAKE_W = $clog2(WB + 1);

  absorb_state_e       state_q, state_d;
  mode_e               mode_q, mode_d;
  logic [RW-1:0]       rate_q, rate_d;
  logic [BW_IBLEN-1:0] rem_q, rem_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [BLK_W-1:0]    buf_q, buf_d;
  logic                last_q, last_d;
  logic                valid_q, ready_q, busy_q;

  logic [TAKE_W-1:0]   take;
  logic [BW_IBLEN-1:0] rem_left;
  logic [RW-1:0]       fill_pos;
  logic [BIT_W-1:0]    bit_base;
  logic [BW_DATA-1:0]  word_m;
  logic [RW-1:0]       pad_pos, pad_rate;
  logic [1:0]          pad_mode;
  logic [BLK_W-1:0]    pad_mask;

  // Word placement: valid byte count of this word and its tail bytes zeroed.
  always_comb begin
    take     = (rem_q < BW_IBLEN'(WB)) ? TAKE_W'(rem_q) : TAKE_W'(WB);
    rem_left = rem_q - BW_IBLEN'(take);
    fill_pos = RW'(wcnt_q) * RW'(WB) + RW'(take);
    bit_base = BIT_W'(wcnt_q) * BIT_W'(BW_DATA);
    word_m   = i_ibytes;
    for (int unsigned b = 0; b < WB; b++) begin
      if (TAKE_W'(b) >= take) word_m[8*b +: 8] = '0;
    end
  end

  // In IDLE the mask must see the incoming mode; in EMIT a padding-only block starts at 0.
  always_comb begin
    pad_rate = (state_q == ST_IDLE) ? RW'(rate_of(mode_e'(i_mode))) : rate_q;
    pad_mode = (state_q == ST_IDLE) ? i_mode : 2'(mode_q);
    pad_pos  = (state_q == ST_FILL) ? fill_pos : '0;
  end

  keccak_pad_mask #(.MAX_RATE(MAX_RATE)) u_pad_mask (
    .pos_i  (pad_pos),
    .rate_i (pad_rate),
    .mode_i (pad_mode),
    .mask_c (pad_mask)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rate_d  = rate_q;
    rem_d   = rem_q;
    wcnt_d  = wcnt_q;
    buf_d   = buf_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          mode_d = mode_e'(i_mode);
          rate_d = pad_rate;
          rem_d  = i_ibytes_len;
          wcnt_d = '0;
          buf_d  = '0;
          if (i_ibytes_len == '0) begin
            buf_d   = pad_mask;
            last_d  = 1'b1;
            state_d = ST_EMIT;
          end else begin
            state_d = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (ready_q && i_ibytes_valid) begin
          buf_d[bit_base +: BW_DATA] = word_m;
          wcnt_d = wcnt_q + WCNT_W'(1);
          rem_d  = rem_left;
          // A byte-full block is never padded here; the tail pad goes in its own block.
          if (fill_pos == rate_q) begin
            state_d = ST_EMIT;
          end else if (rem_left == '0) begin
            buf_d   = buf_d | pad_mask;
            last_d  = 1'b1;
            state_d = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        if (i_blk_ready) begin
          buf_d  = '0;
          wcnt_d = '0;
          if (last_q) begin
            last_d  = 1'b0;
            state_d = ST_IDLE;
          end else if (rem_q != '0) begin
            state_d = ST_FILL;
          end else begin
            buf_d  = pad_mask;
            last_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_SHA3_256;
      rate_q  <= '0;
      rem_q   <= '0;
      wcnt_q  <= '0;
      buf_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rate_q  <= rate_d;
      rem_q   <= rem_d;
      wcnt_q  <= wcnt_d;
      buf_q   <= buf_d;
      last_q  <= last_d;
      valid_q <= (state_d == ST_EMIT);
      ready_q <= (state_d == ST_FILL);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign o_blk          = buf_q;
  assign o_blk_valid    = valid_q;
  assign o_blk_last     = last_q;
  assign o_ibytes_ready = ready_q;
  assign o_busy         = busy_q;

endmodule

// File: tb/tb_keccak_absorb_pad.sv
// Bench for keccak_absorb_pad: 64- and 32-bit instances, expected padded blocks queued per message.
module tb_keccak_absorb_pad;

  localparam int unsigned BLK_W = 168 * 8;
  localparam int          LIMIT = 4000;

  typedef struct {
    logic [BLK_W-1:0] blk;
    logic             last;
    int               nwords;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rstn, st64, st32, v64, v32, blk_ready;
  logic [1:0]       mode;
  logic [10:0]      len;
  logic [63:0]      d64;
  logic [31:0]      d32;
  logic             r64, r32, bv64, bv32, bl64, bl32, bz64, bz32;
  logic [BLK_W-1:0] b64, b32;

  keccak_absorb_pad #(.BW_DATA(64)) u_dut64 (
    .i_clk(clk), .i_rstn(rstn), .i_start(st64), .i_mode(mode), .i_ibytes_len(len),
    .i_ibytes(d64), .i_ibytes_valid(v64), .o_ibytes_ready(r64), .o_blk(b64),
    .o_blk_valid(bv64), .o_blk_last(bl64), .i_blk_ready(blk_ready), .o_busy(bz64)
  );

  keccak_absorb_pad #(.BW_DATA(32)) u_dut32 (
    .i_clk(clk), .i_rstn(rstn), .i_start(st32), .i_mode(mode), .i_ibytes_len(len),
    .i_ibytes(d32), .i_ibytes_valid(v32), .o_ibytes_ready(r32), .o_blk(b32),
    .o_blk_valid(bv32), .o_blk_last(bl32), .i_blk_ready(blk_ready), .o_busy(bz32)
  );

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_blk(input string tag, input logic [BLK_W-1:0] obs, input logic [BLK_W-1:0] exp);
    int k;
    k = 0;
    checks++;
    assert (obs === exp) else begin
      failures++;
      for (int i = 0; i < 168; i++) begin
        if (obs[8*i +: 8] !== exp[8*i +: 8]) begin
          k = i;
          break;
        end
      end
      $error("FAIL %s byte %0d observed=%02h expected=%02h", tag, k, obs[8*k +: 8], exp[8*k +: 8]);
    end
  endtask

  function automatic int rate_for(input logic [1:0] m);
    case (m)
      2'd1:    return 72;
      2'd2:    return 168;
      default: return 136;
    endcase
  endfunction

  // Whole padded message first, then sliced into rate-sized blocks.
  task automatic push_expected(input logic [1:0] m, input int ln, input logic [7:0] seed, input int wb);
    int         r, nblk, db;
    logic [7:0] p[];
    exp_t       e;
    r    = rate_for(m);
    nblk = ln / r + 1;
    p    = new[nblk * r];
    foreach (p[j]) p[j] = (j < ln) ? 8'(j) + seed : 8'h00;
    p[ln]         = p[ln] | ((m >= 2'd2) ? 8'h1F : 8'h06);
    p[nblk*r - 1] = p[nblk*r - 1] | 8'h80;
    for (int b = 0; b < nblk; b++) begin
      e.blk = '0;
      for (int k = 0; k < r; k++) e.blk[8*k +: 8] = p[b*r + k];
      e.last = (b == nblk - 1);
      db = ln - b * r;
      if (db < 0) db = 0;
      if (db > r) db = r;
      e.nwords = (db + wb - 1) / wb;
      sb.push_back(e);
    end
  endtask

  task automatic run_msg(input string name, input bit w32, input logic [1:0] m, input int ln,
                         input logic [7:0] seed, input int stall);
    int               wb, sent, cyc, stall_cnt, idle_cyc, idx;
    bit               acc, fin;
    exp_t             e;
    logic [63:0]      word;
    logic             obs_v, obs_r, obs_l, obs_z;
    logic [BLK_W-1:0] obs_blk;
    wb = w32 ? 4 : 8;
    sent = 0; cyc = 0; stall_cnt = 0; idle_cyc = 0; acc = 0; fin = 0;
    push_expected(m, ln, seed, wb);
    @(negedge clk);
    mode = m;
    len  = 11'(ln);
    if (w32) st32 = 1'b1; else st64 = 1'b1;
    @(negedge clk);
    st32 = 1'b0;
    st64 = 1'b0;
    forever begin
      if (acc) sent += wb;
      acc = 0; v32 = 1'b0; v64 = 1'b0; blk_ready = 1'b0;
      obs_v   = w32 ? bv32 : bv64;
      obs_r   = w32 ? r32 : r64;
      obs_l   = w32 ? bl32 : bl64;
      obs_z   = w32 ? bz32 : bz64;
      obs_blk = w32 ? b32 : b64;
      if (fin) begin
        chk_int({name, "/busy_after_last"}, int'(obs_z), 0);
        chk_int({name, "/valid_after_last"}, int'(obs_v), 0);
        break;
      end
      if (cyc >= LIMIT) begin
        checks++;
        failures++;
        $error("FAIL %s/timeout observed=%0d cycles expected=<%0d", name, cyc, LIMIT);
        sb.delete();
        break;
      end
      if (obs_v) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $error("FAIL %s/extra_block observed=valid expected=no block", name);
          break;
        end
        e = sb[0];
        if (stall_cnt == 0) chk_int({name, "/fill_cycles"}, idle_cyc, e.nwords);
        chk_int({name, "/ready_in_emit"}, int'(obs_r), 0);
        chk_blk({name, "/blk"}, obs_blk, e.blk);
        chk_int({name, "/last"}, int'(obs_l), int'(e.last));
        if (stall_cnt < stall) begin
          stall_cnt++;
        end else begin
          blk_ready = 1'b1;
          void'(sb.pop_front());
          stall_cnt = 0;
          idle_cyc  = 0;
          fin       = e.last;
        end
      end else begin
        idle_cyc++;
        if (obs_r) begin
          for (int b = 0; b < wb; b++) begin
            idx = sent + b;
            word[8*b +: 8] = (idx < ln) ? 8'(idx) + seed : 8'hFF;
          end
          if (w32) begin d32 = word[31:0]; v32 = 1'b1; end
          else     begin d64 = word;       v64 = 1'b1; end
          acc = 1;
        end
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    rstn = 1'b0; st64 = 1'b0; st32 = 1'b0; v64 = 1'b0; v32 = 1'b0;
    d64 = '0; d32 = '0; mode = '0; len = '0; blk_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_int("reset/valid", int'(bv64), 0);
    chk_int("reset/ready", int'(r64), 0);
    chk_int("reset/busy", int'(bz64), 0);
    chk_int("reset/last", int'(bl64), 0);
    chk_blk("reset/blk", b64, '0);
    chk_int("reset/valid32", int'(bv32), 0);
    rstn = 1'b1;
    @(negedge clk);

    run_msg("sha3_256_len0",        1'b0, 2'd0, 0,   8'h00, 0);
    run_msg("sha3_512_len71",       1'b0, 2'd1, 71,  8'h00, 0);
    run_msg("shake128_len168",      1'b0, 2'd2, 168, 8'h30, 0);
    run_msg("shake256_w32_len5",    1'b1, 2'd3, 5,   8'hFB, 0);
    run_msg("sha3_256_len300_stall",1'b0, 2'd0, 300, 8'h11, 7);
    run_msg("sha3_512_w32_len71",   1'b1, 2'd1, 71,  8'h5A, 2);
    run_msg("shake128_w32_len336",  1'b1, 2'd2, 336, 8'h77, 1);

    // Abort a message in the middle of FILL.
    @(negedge clk);
    mode = 2'd0;
    len  = 11'd100;
    st64 = 1'b1;
    @(negedge clk);
    st64 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d64 = {8{8'hA5}} ^ 64'(i);
      v64 = 1'b1;
      @(negedge clk);
    end
    v64  = 1'b0;
    rstn = 1'b0;
    #1;
    chk_int("midreset/valid", int'(bv64), 0);
    chk_int("midreset/ready", int'(r64), 0);
    chk_int("midreset/busy", int'(bz64), 0);
    chk_int("midreset/last", int'(bl64), 0);
    chk_blk("midreset/blk", b64, '0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    run_msg("after_reset_len100",   1'b0, 2'd0, 100, 8'h42, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
